// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
//
// Controller for a direct-mapped instruction cache. It looks up fetches in an
// external tag/valid/data RAM, refills missing lines over an AXI read burst,
// and invalidates the whole cache on request.
//
// Lookup path:
//   An accepted fetch drives the RAM index straight from cpu_addr, so the
//   data RAM (one cycle of read latency) and the tag RAM (combinational read)
//   both present their results in the following LOOKUP cycle. A hit answers in
//   that cycle. A miss issues one INCR burst for the full line, collects the
//   beats in a line buffer, writes the line in a single cycle, and then
//   returns the requested (critical) word from the buffer.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   cpu_req/cpu_addr           fetch request and byte address
//   cpu_ready                  request accepted when cpu_req && cpu_ready
//   cpu_rvalid/cpu_rdata       one-cycle response strobe and instruction word
//   flush_req/flush_done       invalidate-all request / one-cycle completion
//   ram_a, ram_dpra            write/data-read index, tag/valid read index
//   ram_wen, ram_d, ram_dina,  line write strobe, tag, line data and
//   ram_w_valid                valid bit to store
//   ram_dpo, ram_douta,        tag read (combinational), line read
//   ram_cache_valid            (registered), valid bit read
//   ar*/r*                     AXI read address and read data channels
// -----------------------------------------------------------------------------
module icache_ctrl #(
    parameter int INDEX_SIZE    = 6,
    parameter int WORD_OFF_SIZE = 4,
    parameter int TAG_SIZE      = 20
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic                                cpu_req,
    input  logic [31:0]                         cpu_addr,
    output logic                                cpu_ready,
    output logic                                cpu_rvalid,
    output logic [31:0]                         cpu_rdata,

    input  logic                                flush_req,
    output logic                                flush_done,

    output logic [INDEX_SIZE-1:0]               ram_a,
    output logic [INDEX_SIZE-1:0]               ram_dpra,
    output logic                                ram_wen,
    output logic [TAG_SIZE-1:0]                 ram_d,
    output logic [(32<<WORD_OFF_SIZE)-1:0]      ram_dina,
    output logic                                ram_w_valid,
    input  logic [TAG_SIZE-1:0]                 ram_dpo,
    input  logic [(32<<WORD_OFF_SIZE)-1:0]      ram_douta,
    input  logic                                ram_cache_valid,

    output logic                                arvalid,
    input  logic                                arready,
    output logic [31:0]                         araddr,
    output logic [7:0]                          arlen,
    output logic [2:0]                          arsize,
    output logic [1:0]                          arburst,
    input  logic                                rvalid,
    output logic                                rready,
    input  logic [31:0]                         rdata,
    input  logic                                rlast
);

    localparam int WORDS   = 1 << WORD_OFF_SIZE;
    localparam int IDX_LSB = WORD_OFF_SIZE + 2;         // first index bit of a byte address
    localparam int TAG_LSB = IDX_LSB + INDEX_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        REFILL,
        WRITE,
        RESP,
        FLUSH
    } state_t;

    state_t                     state_reg, state_next;
    logic [31:0]                addr_reg, addr_next;
    logic [WORD_OFF_SIZE-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [INDEX_SIZE-1:0]      flush_idx_reg, flush_idx_next;
    logic                       flush_pend_reg, flush_pend_next;

    logic [31:0]                line_buf_reg [WORDS];
    logic [31:0]                douta_word [WORDS];

    logic [INDEX_SIZE-1:0]      cpu_index;
    logic [INDEX_SIZE-1:0]      addr_index;
    logic [TAG_SIZE-1:0]        addr_tag;
    logic [WORD_OFF_SIZE-1:0]   addr_word;
    logic                       lookup_hit;

    assign cpu_index  = cpu_addr[IDX_LSB +: INDEX_SIZE];
    assign addr_index = addr_reg[IDX_LSB +: INDEX_SIZE];
    assign addr_tag   = addr_reg[TAG_LSB +: TAG_SIZE];
    assign addr_word  = addr_reg[2 +: WORD_OFF_SIZE];
    assign lookup_hit = ram_cache_valid && (ram_dpo == addr_tag);

    // Word views of the RAM read port and of the line buffer going to the RAM.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_words
            assign douta_word[gi]          = ram_douta[32*gi +: 32];
            assign ram_dina[32*gi +: 32]   = line_buf_reg[gi];
        end
    endgenerate

    // Burst request is derived from the latched address only, so it cannot
    // change while arvalid waits for arready.
    assign araddr  = {addr_reg[31:IDX_LSB], {IDX_LSB{1'b0}}};
    assign arlen   = 8'(WORDS - 1);
    assign arsize  = 3'd2;                              // 4-byte beats
    assign arburst = 2'b01;                             // INCR

    // Byte-offset bits and rlast carry no information: the beat counter
    // decides when the line is complete.
    logic unused_sigs;
    assign unused_sigs = &{1'b0, rlast, addr_reg[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            beat_cnt_reg   <= '0;
            flush_idx_reg  <= '0;
            flush_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            beat_cnt_reg   <= beat_cnt_next;
            flush_idx_reg  <= flush_idx_next;
            flush_pend_reg <= flush_pend_next;
        end
    end

    // Line buffer has no reset: its contents only matter after a full refill.
    always_ff @(posedge clk) begin
        if (state_reg == REFILL && rvalid) begin
            line_buf_reg[beat_cnt_reg] <= rdata;
        end
    end

    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        beat_cnt_next   = beat_cnt_reg;
        flush_idx_next  = flush_idx_reg;
        flush_pend_next = flush_pend_reg;

        cpu_ready   = 1'b0;
        cpu_rvalid  = 1'b0;
        cpu_rdata   = '0;
        flush_done  = 1'b0;
        ram_a       = addr_index;
        ram_dpra    = addr_index;
        ram_wen     = 1'b0;
        ram_d       = '0;
        ram_w_valid = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;

        // A flush request seen while busy is remembered until the next IDLE.
        if (state_reg != IDLE && flush_req) begin
            flush_pend_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                // Index goes straight to the RAMs so the lookup data is ready
                // one cycle after acceptance.
                ram_a    = cpu_index;
                ram_dpra = cpu_index;
                if (flush_req || flush_pend_reg) begin
                    state_next      = FLUSH;
                    flush_idx_next  = '0;
                    flush_pend_next = 1'b0;
                end else begin
                    cpu_ready = 1'b1;
                    if (cpu_req) begin
                        addr_next  = cpu_addr;
                        state_next = LOOKUP;
                    end
                end
            end

            LOOKUP: begin
                if (lookup_hit) begin
                    cpu_rvalid = 1'b1;
                    cpu_rdata  = douta_word[addr_word];
                    state_next = IDLE;
                end else begin
                    state_next = MISS;
                end
            end

            MISS: begin
                arvalid = 1'b1;
                if (arready) begin
                    beat_cnt_next = '0;
                    state_next    = REFILL;
                end
            end

            REFILL: begin
                rready = 1'b1;
                if (rvalid) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (&beat_cnt_reg) begin
                        state_next = WRITE;
                    end
                end
            end

            WRITE: begin
                ram_wen     = 1'b1;
                ram_d       = addr_tag;
                ram_w_valid = 1'b1;
                state_next  = RESP;
            end

            RESP: begin
                // Critical word comes from the freshly filled line buffer.
                cpu_rvalid = 1'b1;
                cpu_rdata  = line_buf_reg[addr_word];
                state_next = IDLE;
            end

            FLUSH: begin
                ram_a          = flush_idx_reg;
                ram_dpra       = flush_idx_reg;
                ram_wen        = 1'b1;
                flush_idx_next = flush_idx_reg + 1'b1;
                if (&flush_idx_reg) begin
                    flush_done = 1'b1;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_SIZE, default 6, meaning line-index width (64 lines).
REQ-002 SHALL have parameter WORD_OFF_SIZE, default 4, meaning word-offset width (16 x 32-bit words per line).
REQ-003 SHALL have parameter TAG_SIZE, default 20, meaning tag width; TAG_SIZE+INDEX_SIZE+WORD_OFF_SIZE+2 = 32.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req  in  1  fetch request; cpu_addr  in  32  fetch byte address.
REQ-007 cpu_ready  out  1  request accepted this cycle when cpu_req&&cpu_ready.
REQ-008 cpu_rvalid  out  1  one-cycle response strobe; cpu_rdata  out  32  instruction word.
REQ-009 flush_req  in  1  invalidate-all request; flush_done  out  1  one-cycle completion pulse.
REQ-010 ram_a  out  6  RAM write/data-read index; ram_dpra  out  6  tag/valid read index.
REQ-011 ram_wen  out  1; ram_d  out  20  tag to write; ram_dina  out  512  line to write; ram_w_valid  out  1.
REQ-012 ram_dpo  in  20  tag read (combinational from ram_dpra); ram_douta  in  512  data read (1-cycle latency from ram_a); ram_cache_valid  in  1.
REQ-013 AXI read: arvalid out 1, arready in 1, araddr out 32, arlen out 8, arsize out 3, arburst out 2; rvalid in 1, rready out 1, rdata in 32, rlast in 1.

Function
REQ-014 States SHALL be IDLE, LOOKUP, MISS, REFILL, WRITE, RESP, FLUSH.
REQ-015 IDLE: cpu_ready=1 unless flush_req=1; flush_req has priority over cpu_req -> FLUSH, idx counter=0.
REQ-016 IDLE accept: ram_a=ram_dpra=cpu_addr[11:6] combinationally; latch cpu_addr; -> LOOKUP.
REQ-017 Non-IDLE: ram_a and ram_dpra SHALL be driven from latched index (FLUSH: from idx counter).
REQ-018 LOOKUP: hit = ram_cache_valid && ram_dpo==latched tag.
REQ-019 Hit: cpu_rvalid=1, cpu_rdata=ram_douta[32*w+31:32*w], w=latched addr[5:2]; -> IDLE; hit latency 1 cycle after accept.
REQ-020 Miss: -> MISS; cpu_rvalid=0.
REQ-021 MISS: arvalid=1, araddr={tag,index,6'b0}, arlen=15, arsize=2, arburst=INCR(01); hold stable until arready; on handshake -> REFILL, beat counter=0.
REQ-022 REFILL: rready=1; each rvalid beat k stored to line buffer bits [32k+31:32k], counter increments (4-bit).
REQ-023 Beat 15 accepted -> WRITE regardless of rlast; rlast on earlier beat SHALL be ignored (counter governs).
REQ-024 WRITE: exactly one cycle ram_wen=1, ram_a=index, ram_d=tag, ram_dina=line buffer, ram_w_valid=1; -> RESP.
REQ-025 RESP: cpu_rvalid=1, cpu_rdata=line buffer word w (critical word); -> IDLE.
REQ-026 FLUSH: per cycle ram_wen=1, ram_a=idx, ram_w_valid=0, ram_d=0; idx increments; at idx=63 write, flush_done=1 same cycle, -> IDLE; total 64 cycles.
REQ-027 cpu_ready=0 in all states except IDLE; cpu_req ignored outside IDLE.
REQ-028 flush_req arriving outside IDLE SHALL be held pending (sticky) and serviced at next IDLE entry before any cpu_req.
REQ-029 ram_wen SHALL be 0 except in WRITE and FLUSH; arvalid only in MISS; rready only in REFILL.

Reset
REQ-030 reset=1 at edge: state=IDLE, cpu_rvalid=0, cpu_rdata=0, flush_done=0, arvalid=0, rready=0, ram_wen=0, ram_w_valid=0, pending flush cleared, counters 0.
REQ-031 Reset mid-MISS/REFILL/FLUSH SHALL abort with no further RAM write; line buffer content undefined; AXI slave reset jointly.
REQ-032 Valid bits are not cleared by this block on reset; a flush is required.

Verification
REQ-033 Flush from reset: flush_req=1 one cycle -> 64 consecutive ram_wen with w_valid=0, idx 0..63, flush_done at 64th.
REQ-034 Cold miss addr 0x0000_1044: araddr=0x0000_1040, arlen=15; beats 0x100+k; WRITE at ram_a=1, ram_d=0x00001; RESP cpu_rdata=0x101.
REQ-035 Re-fetch 0x0000_1048 after REQ-034: cpu_rvalid one cycle after accept, data=word 2, no arvalid.
REQ-036 Tag conflict 0x0000_2040 after fill: miss, refill, ram_d=0x00002, ram_a=1.
REQ-037 arready held low 5 cycles, rvalid gaps, and flush_req during REFILL: araddr stable, beats counted correctly, flush executes after RESP.
REQ-038 reset asserted at beat 7 of refill: no ram_wen, state IDLE, cpu_ready=1 next cycle.
